nan_gate_sequencer: RTL and testbench
=====================================

Name: nan_gate_sequencer

Overview:
- Time-multiplexes one shared NaN-gate evaluator over a small loadable netlist program.
- Holds an fp3 register file and evaluates one gate per clock.
- Converts input bits to fp3 on start and converts selected registers back to bits on completion.
- Lets arbitrary NOR-complete logic run on the fp3 datapath without instantiating one gate per node.

Parameters:
- NREGS, 16: fp3 register-file depth, power of 2, at least NIN+NOUT.
- NINSTR, 32: program memory depth, power of 2.
- NIN, 4: input bits, loaded into regs 0..NIN-1.
- NOUT, 4: output bits, read from regs NREGS-NOUT..NREGS-1; out_bits[i] comes from reg NREGS-NOUT+i.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- prog_we  input  1  program write strobe
- prog_addr  input  log2(NINSTR)  program write address
- prog_data  input  3*log2(NREGS)  instruction {dst, srcb, srca}, srca in the LSBs
- prog_len  input  log2(NINSTR)+1  instruction count, sampled on start; 0..NINSTR
- start  input  1  run request, sampled only in IDLE
- in_bits  input  NIN  input bits, sampled on start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- out_valid  output  1  out_bits hold a completed result
- out_bits  output  NOUT  result bits

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- fp3 encoding: bit2 is sign; bits1:0 are 00 zero, 01 one, 10 inf, 11 NaN. Constants: PINF=010, PNAN=011.
- Bit to fp3 conversion: 1 maps to PNAN, 0 maps to PINF.
- fp3 to bit conversion: 1 iff bits1:0==11, any sign.
- Gate function Y=nan(A,B), evaluated in priority order:
  - either operand NaN -> PINF;
  - {PINF,NINF} or {NINF,PINF} -> PINF;
  - either operand PINF (010) -> PNAN;
  - otherwise -> PINF.
  - On converted bits this is NOR.
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, done=0, out_valid=0, out_bits=0; all regs=PINF. Program memory has no reset and retains its contents across rst_n.
- FSM states: IDLE, LOAD, RUN, FINISH.
  - IDLE: on start=1, latch prog_len and in_bits, go to LOAD. prog_we writes program memory only in IDLE; it is ignored otherwise.
  - LOAD (1 cycle): regs[0..NIN-1] take the converted in_bits; all other regs take PINF; pc=0; out_valid cleared. Go to RUN if len>0, else FINISH.
  - RUN: each cycle, regs[dst] <= nan(regs[srca], regs[srcb]); pc++. After instruction len-1, go to FINISH.
  - FINISH (1 cycle): out_bits <= converted output regs; out_valid <= 1; done <= 1 for exactly one cycle; go to IDLE.
- Dependencies: a register written by instruction k is visible to instruction k+1. There are no hazards and no stalls.
- Any dst is legal, including input regs 0..NIN-1; srca==srcb is legal.
- Latency: start sampled at edge E0 -> done and out_valid high, busy low, from edge E(prog_len+2).
- Boundary conditions:
  - start while busy: ignored and not queued.
  - start held high across done: a new run begins on the first IDLE cycle.
  - prog_len=0: done at E2; out_bits=0, unless NOUT regs overlap input regs, in which case those bits follow the inputs.
  - prog_len>NINSTR: clamped to NINSTR.
  - pc reaches NINSTR-1: terminates without wrap-around.
  - out_valid stays high until the next LOAD or reset.
  - rst_n asserted mid-run: immediate abort to IDLE with the reset values above; no done pulse.

Optional Feature:
- Macro: NAN_GATE_SEQUENCER_TRACE_EN.
- Defined: adds output ports trace_valid (1), trace_pc (log2(NINSTR)), trace_dst (log2(NREGS)) and trace_val (3). These are registered copies of each RUN cycle's pc, dst and result, valid one cycle after the write. trace_valid is low outside RUN+1; all trace ports reset to 0.
- Undefined: the ports do not exist and the logic is removed. Core timing is identical in both builds.

Test Plan:
- NOT chain: program [r4=nan(r0,r0); r15=nan(r4,r4)], len=2, in_bits=0001 -> done at E4; r4=PINF then r15=PNAN; out_bits[3]=1. Repeat with in_bits=0000 -> out_bits[3]=0.
- NOR truth table: r15=nan(r0,r1), len=1, drive all four combinations of in_bits[1:0] -> out_bits[3]=1 only for 00; done exactly 3 cycles after start.
- XOR from 4 NOR plus NOT, 5 instructions, all 4 input combinations -> out_bits[3]=in[0]^in[1]; busy high for 7 cycles.
- prog_len=0 -> busy for 2 cycles, done pulse at E2, out_bits=0000, out_valid=1.
- start and prog_we asserted mid-RUN -> no restart, program unchanged, single done pulse.
- rst_n pulsed low at RUN pc=1 -> busy=0, done never pulses, out_valid=0. A following start with the retained program yields the correct result.

Source files
------------

// File: rtl/nan_gate_sequencer.sv
// nan_gate_sequencer: runs a loadable netlist of NaN gates (NOR on converted
// bits) one gate per clock over a small fp3 register file.
// Optional build macro NAN_GATE_SEQUENCER_TRACE_EN adds a registered trace
// port reporting each executed instruction one cycle after its write.
module nan_gate_sequencer #(
    parameter int NREGS  = 16,
    parameter int NINSTR = 32,
    parameter int NIN    = 4,
    parameter int NOUT   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         prog_we,
    input  logic [$clog2(NINSTR)-1:0]    prog_addr,
    input  logic [3*$clog2(NREGS)-1:0]   prog_data,
    input  logic [$clog2(NINSTR):0]      prog_len,
    input  logic                         start,
    input  logic [NIN-1:0]               in_bits,
    output logic                         busy,
    output logic                         done,
    output logic                         out_valid,
    output logic [NOUT-1:0]              out_bits
`ifdef NAN_GATE_SEQUENCER_TRACE_EN
    ,
    output logic                         trace_valid,
    output logic [$clog2(NINSTR)-1:0]    trace_pc,
    output logic [$clog2(NREGS)-1:0]     trace_dst,
    output logic [2:0]                   trace_val
`endif
);

    localparam int RW = $clog2(NREGS);
    localparam int PW = $clog2(NINSTR);
    localparam logic [PW:0] LEN_MAX = (PW+1)'(NINSTR);

    localparam logic [2:0] PINF = 3'b010;
    localparam logic [2:0] NINF = 3'b110;
    localparam logic [2:0] PNAN = 3'b011;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

    state_t              state_reg;
    logic [PW-1:0]       pc_reg;
    logic [PW:0]         len_reg;
    logic [NIN-1:0]      in_reg;
    logic [2:0]          regs_reg [NREGS];
    logic [3*RW-1:0]     prog_mem [NINSTR];
    logic [3*RW-1:0]     instr_reg;

    logic [PW-1:0]       fetch_addr;
    logic [RW-1:0]       srca, srcb, dst;
    logic [2:0]          gate_y;
    logic                last_instr;
    logic [NREGS-1:0]    load_bits;
    logic [NOUT-1:0]     out_next;
    logic [PW:0]         len_clamped;

    // NaN gate: NaN operands dominate, then the +inf/-inf pair, then any +inf.
    function automatic logic [2:0] nan_fn(input logic [2:0] a, input logic [2:0] b);
        if (a[1:0] == 2'b11 || b[1:0] == 2'b11)
            return PINF;
        if ((a == PINF && b == NINF) || (a == NINF && b == PINF))
            return PINF;
        if (a == PINF || b == PINF)
            return PNAN;
        return PINF;
    endfunction

    assign srca        = instr_reg[RW-1:0];
    assign srcb        = instr_reg[2*RW-1:RW];
    assign dst         = instr_reg[3*RW-1:2*RW];
    assign gate_y      = nan_fn(regs_reg[srca], regs_reg[srcb]);
    assign last_instr  = ({1'b0, pc_reg} == (len_reg - 1'b1));
    assign load_bits   = NREGS'(in_reg);
    assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

    // Prefetch: the instruction for the next RUN cycle is read one cycle
    // early so program memory can use a registered read port.
    assign fetch_addr = (state_reg == RUN) ? pc_reg + 1'b1 : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NOUT; gi++) begin : g_out_conv
            assign out_next[gi] = (regs_reg[NREGS-NOUT+gi][1:0] == 2'b11);
        end
    endgenerate

    // Program memory: written only while idle, never reset, registered read.
    always_ff @(posedge clk) begin
        if (prog_we && state_reg == IDLE)
            prog_mem[prog_addr] <= prog_data;
        instr_reg <= prog_mem[fetch_addr];
    end

    // Register file: bulk init on LOAD, one gate result written per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_reg[i] <= PINF;
        end else if (state_reg == LOAD) begin
            for (int i = 0; i < NREGS; i++)
                regs_reg[i] <= load_bits[i] ? PNAN : PINF;
        end else if (state_reg == RUN) begin
            regs_reg[dst] <= gate_y;
        end
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            len_reg   <= '0;
            in_reg    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_bits  <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_reg   <= len_clamped;
                        in_reg    <= in_bits;
                        busy      <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    pc_reg    <= '0;
                    out_valid <= 1'b0;
                    state_reg <= (len_reg == '0) ? FINISH : RUN;
                end
                RUN: begin
                    if (last_instr)
                        state_reg <= FINISH;
                    else
                        pc_reg <= pc_reg + 1'b1;
                end
                FINISH: begin
                    out_bits  <= out_next;
                    out_valid <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef NAN_GATE_SEQUENCER_TRACE_EN
    // Trace: registered copy of each executed instruction and its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_dst   <= '0;
            trace_val   <= '0;
        end else begin
            trace_valid <= (state_reg == RUN);
            if (state_reg == RUN) begin
                trace_pc  <= pc_reg;
                trace_dst <= dst;
                trace_val <= gate_y;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nan_gate_sequencer.sv
// Testbench for nan_gate_sequencer: fixed-program vector table, multi-cycle
// corner sequences, and random programs against a boolean NOR model.
`timescale 1ns/1ps
module tb_nan_gate_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [11:0] prog_data;
    logic [5:0]  prog_len;
    logic        start;
    logic [3:0]  in_bits;
    logic        busy, done, out_valid;
    logic [3:0]  out_bits;

    int checks = 0;
    int errors = 0;

    logic [11:0] tb_prog [32];

    nan_gate_sequencer #(.NREGS(16), .NINSTR(32), .NIN(4), .NOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start),
        .in_bits(in_bits), .busy(busy), .done(done), .out_valid(out_valid),
        .out_bits(out_bits)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ins(input int d, input int b, input int a);
        return {4'(d), 4'(b), 4'(a)};
    endfunction

    // Reference: registers hold plain bits, every gate is a NOR.
    function automatic logic [3:0] model(input int len, input logic [3:0] inb);
        bit r [16];
        int n;
        logic [3:0] res;
        for (int i = 0; i < 16; i++) r[i] = 1'b0;
        for (int i = 0; i < 4; i++) r[i] = inb[i];
        n = (len > 32) ? 32 : len;
        for (int k = 0; k < n; k++)
            r[tb_prog[k][11:8]] = !(r[tb_prog[k][3:0]] | r[tb_prog[k][7:4]]);
        for (int i = 0; i < 4; i++) res[i] = r[12+i];
        return res;
    endfunction

    task automatic write_instr(input int addr, input logic [11:0] data);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 5'(addr); prog_data = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
        tb_prog[addr] = data;
    endtask

    task automatic load_program(input int id);
        case (id)
            0: begin
                write_instr(0, ins(4, 0, 0));
                write_instr(1, ins(15, 4, 4));
            end
            1: write_instr(0, ins(15, 1, 0));
            default: begin
                write_instr(0, ins(4, 1, 0));
                write_instr(1, ins(5, 4, 0));
                write_instr(2, ins(6, 4, 1));
                write_instr(3, ins(7, 6, 5));
                write_instr(4, ins(15, 7, 7));
            end
        endcase
    endtask

    // One run: start sampled at E0; returns result, cycles to done, busy cycles.
    task automatic run_prog(input int len, input logic [3:0] inb, input string tag,
                            output logic [3:0] ob, output int lat, output int bcnt);
        @(negedge clk);
        prog_len = 6'(len); in_bits = inb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        ob = out_bits;
        check({tag, " out_valid@done"}, 32'(out_valid), 32'd1);
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " done one-cycle"}, 32'(done), 32'd0);
        check({tag, " out_valid holds"}, 32'(out_valid), 32'd1);
    endtask

    typedef struct {
        int         prog;
        int         len;
        logic [3:0] inb;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [3:0] ob;
        int lat, bcnt, pulses, n, len;
        logic [3:0] inb;
        int cur;

        vecs[0]  = '{0, 2, 4'b0001, 4'b1000};
        vecs[1]  = '{0, 2, 4'b0000, 4'b0000};
        vecs[2]  = '{1, 1, 4'b0000, 4'b1000};
        vecs[3]  = '{1, 1, 4'b0001, 4'b0000};
        vecs[4]  = '{1, 1, 4'b0010, 4'b0000};
        vecs[5]  = '{1, 1, 4'b0011, 4'b0000};
        vecs[6]  = '{2, 5, 4'b0000, 4'b0000};
        vecs[7]  = '{2, 5, 4'b0001, 4'b1000};
        vecs[8]  = '{2, 5, 4'b0010, 4'b1000};
        vecs[9]  = '{2, 5, 4'b0011, 4'b0000};
        vecs[10] = '{2, 0, 4'b1111, 4'b0000};
        vecs[11] = '{2, 5, 4'b1110, 4'b1000};

        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; in_bits = '0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_bits", 32'(out_bits), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Fixed programs
        cur = -1;
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].prog != cur) begin
                load_program(vecs[v].prog);
                cur = vecs[v].prog;
            end
            run_prog(vecs[v].len, vecs[v].inb, $sformatf("vec%0d", v), ob, lat, bcnt);
            check($sformatf("vec%0d out_bits", v), 32'(ob), 32'(vecs[v].exp));
            check($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].len + 2));
            check($sformatf("vec%0d busy cycles", v), 32'(bcnt), 32'(vecs[v].len + 2));
        end

        // start and prog_we during RUN are ignored (XOR program still loaded)
        @(negedge clk);
        prog_len = 6'd5; in_bits = 4'b0000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; prog_we = 1'b1; prog_addr = 5'd0; prog_data = ins(15, 2, 2);
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        pulses = 0; ob = 4'hf;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (pulses == 1) ob = out_bits;
            end
        end
        check("midrun done pulses", 32'(pulses), 32'd1);
        check("midrun out_bits", 32'(ob), 32'(model(5, 4'b0000)));
        run_prog(5, 4'b0000, "after midrun", ob, lat, bcnt);
        check("program unchanged", 32'(ob), 32'd0);

        // start held high across done restarts on the first idle cycle
        @(negedge clk);
        prog_len = 6'd0; in_bits = 4'b0000; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("held start done@E2", 32'(done), 32'd1);
        check("held start busy@E2", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("held start busy@E3", 32'(busy), 32'd1);
        check("held start done@E3", 32'(done), 32'd0);
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("held start second done", 32'(n), 32'd2);

        // asynchronous reset at RUN pc=1 aborts without a done pulse
        @(negedge clk);
        prog_len = 6'd5; in_bits = 4'b0001; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort out_bits", 32'(out_bits), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("abort no done", 32'(pulses), 32'd0);
        run_prog(5, 4'b0001, "after abort", ob, lat, bcnt);
        check("after abort out_bits", 32'(ob), 32'b1000);

        // Random programs, lengths (including >NINSTR) and inputs
        for (int t = 0; t < 25; t++) begin
            for (int a = 0; a < 32; a++)
                write_instr(a, 12'($urandom));
            len = int'($urandom_range(0, 63));
            inb = 4'($urandom);
            run_prog(len, inb, $sformatf("rand%0d", t), ob, lat, bcnt);
            check($sformatf("rand%0d len%0d out_bits", t, len), 32'(ob), 32'(model(len, inb)));
            check($sformatf("rand%0d latency", t), 32'(lat), 32'(((len > 32) ? 32 : len) + 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
